// File: rtl/rnd_num_gen.sv
`default_nettype none
// ============================================================================
// Module   : rnd_num_gen
// Brief    : Galois-LFSR random word responder with a small prefetch FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rnd_num_gen #(
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter logic [31:0] POLY       = 32'h8020_0003,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          rnd_num_req_i,
  output logic [31:0]                   rnd_num_o,
  output logic                          rnd_num_valid_o,
  output logic                          underrun_o,
  input  logic                          reseed_i,
  input  logic [31:0]                   seed_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int          c_addr_w = $clog2(FIFO_DEPTH);
  localparam int          c_lvl_w  = c_addr_w + 1;
  localparam logic [31:0] c_seed   = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [31:0]         r_lfsr;
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0]  r_level;
  logic [31:0]         r_rnd_num;
  logic                r_valid;
  logic                r_underrun;

  logic [31:0] w_lfsr_next;
  logic [31:0] w_seed;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? POLY : 32'd0);
  assign w_seed      = (seed_i == 32'd0) ? 32'd1 : seed_i;
  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == c_lvl_w'(FIFO_DEPTH));

  // Reseed overrides both FIFO operations; a full FIFO may still push when popped.
  assign w_pop  = rnd_num_req_i && !w_empty && !reseed_i;
  assign w_push = !reseed_i && (!w_full || w_pop);

  // Storage carries no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_lfsr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lfsr     <= c_seed;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rnd_num  <= '0;
      r_valid    <= 1'b0;
      r_underrun <= 1'b0;
    end else if (reseed_i) begin
      r_lfsr     <= w_seed;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_valid    <= 1'b0;
      r_underrun <= rnd_num_req_i;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
        r_lfsr   <= w_lfsr_next;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + c_addr_w'(1);
        r_rnd_num <= r_mem[r_rd_ptr];
      end
      r_valid    <= w_pop;
      r_underrun <= rnd_num_req_i && w_empty;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rnd_num_o       = r_rnd_num;
  assign rnd_num_valid_o = r_valid;
  assign underrun_o      = r_underrun;
  assign fifo_level_o    = r_level;

endmodule
`default_nettype wire

// File: tb/tb_rnd_num_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rnd_num_gen
// Brief    : Self-checking bench for rnd_num_gen against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rnd_num_gen;

  localparam logic [31:0] c_seed  = 32'h0000_0001;
  localparam logic [31:0] c_poly  = 32'h8020_0003;
  localparam int          c_depth = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rnd_num_req_i = 1'b0;
  logic        reseed_i = 1'b0;
  logic [31:0] seed_i = 32'd0;
  logic [31:0] rnd_num_o;
  logic        rnd_num_valid_o;
  logic        underrun_o;
  logic [2:0]  fifo_level_o;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [31:0] m_lfsr;
  logic [31:0] m_q[$];
  logic [31:0] m_out;
  logic        m_valid;
  logic        m_under;

  rnd_num_gen #(.SEED(c_seed), .POLY(c_poly), .FIFO_DEPTH(c_depth)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rnd_num_req_i   (rnd_num_req_i),
    .rnd_num_o       (rnd_num_o),
    .rnd_num_valid_o (rnd_num_valid_o),
    .underrun_o      (underrun_o),
    .reseed_i        (reseed_i),
    .seed_i          (seed_i),
    .fifo_level_o    (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (((x & 32'd1) != 0) ? c_poly : 32'd0);
  endfunction

  task automatic model_reset();
    m_lfsr  = c_seed;
    m_q.delete();
    m_out   = 32'd0;
    m_valid = 1'b0;
    m_under = 1'b0;
  endtask

  task automatic check_model();
    chk("rnd_num", rnd_num_o, m_out);
    chk("valid", {31'd0, rnd_num_valid_o}, {31'd0, m_valid});
    chk("underrun", {31'd0, underrun_o}, {31'd0, m_under});
    chk("level", {29'd0, fifo_level_o}, 32'(m_q.size()));
  endtask

  // One clock: drive, let the edge happen, advance the model, compare.
  task automatic step(input logic req, input logic rs, input logic [31:0] sd);
    bit popping, pushing;
    rnd_num_req_i = req;
    reseed_i      = rs;
    seed_i        = sd;
    @(posedge clk_i);
    if (rs) begin
      m_lfsr  = (sd == 0) ? 32'd1 : sd;
      m_q.delete();
      m_valid = 1'b0;
      m_under = req;
    end else begin
      popping = req && (m_q.size() > 0);
      pushing = (m_q.size() < c_depth) || popping;
      m_under = req && !popping;
      m_valid = popping;
      if (popping) m_out = m_q.pop_front();
      if (pushing) begin
        m_q.push_back(m_lfsr);
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rnd_num_req_i = 1'b0;
    reseed_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    check_model();
    rst_i = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_seq [5];
    logic [2:0]  exp_fill [6];
    exp_seq  = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001, 32'hB02C_0003};
    exp_fill = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};

    // Reset fill
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'd0);
      chk("fill_level", {29'd0, fifo_level_o}, {29'd0, exp_fill[i]});
    end

    // Sequence under continuous request
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'd0);
      chk("seq_word", rnd_num_o, exp_seq[i]);
      chk("seq_level", {29'd0, fifo_level_o}, 32'd4);
    end
    step(1'b0, 1'b0, 32'd0);

    // Underrun on the first edge after reset
    do_reset();
    step(1'b1, 1'b0, 32'd0);
    chk("underrun_first", {31'd0, underrun_o}, 32'd1);
    step(1'b1, 1'b0, 32'd0);
    chk("after_underrun", rnd_num_o, 32'h0000_0001);

    // Full FIFO, single pulse
    do_reset();
    repeat (4) step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("full_pop_level", {29'd0, fifo_level_o}, 32'd4);
    chk("full_pop_word", rnd_num_o, 32'h0000_0001);

    // Reseed with zero seed during continuous request
    repeat (3) step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'd0);
    chk("reseed_under", {31'd0, underrun_o}, 32'd1);
    chk("reseed_level", {29'd0, fifo_level_o}, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("reseed_w0", rnd_num_o, 32'h0000_0001);
    step(1'b1, 1'b0, 32'd0);
    chk("reseed_w1", rnd_num_o, 32'h8020_0003);

    // Asynchronous reset between edges while delivering
    repeat (3) step(1'b1, 1'b0, 32'd0);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_out", rnd_num_o, 32'd0);
    chk("arst_valid", {31'd0, rnd_num_valid_o}, 32'd0);
    chk("arst_level", {29'd0, fifo_level_o}, 32'd0);
    do_reset();
    step(1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 32'd0);
    chk("arst_restart", rnd_num_o, 32'h0000_0001);

    // Randomized traffic with occasional reseeds
    for (int i = 0; i < 400; i++) begin
      logic r, s;
      logic [31:0] sd;
      r  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 39) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(r, s, sd);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
